rps_match_controller: RTL

Sequencing controller for the two-player rock-paper-scissors match datapath. It accepts one move per player per round through a ready/valid handshake, then judges the round and updates the round, win and lose counters. After a display hold, it decides whether the match is finished and reports the winner. It sits between the player input logic and the scoreboard/display logic, and owns the counters that the finish check consumes.

---
 rtl/rps_match_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rps_match_controller.sv
// Round sequencer for the two-player rock-paper-scissors match: captures both
// moves, judges the round, holds the result for display and detects match end.
module rps_match_controller #(
  parameter int unsigned ROUNDS      = 8,
  parameter int unsigned SHOW_CYCLES = 4,
  parameter int unsigned EARLY_FIN   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] p1_move,
  input  logic       p1_valid,
  output logic       p1_ready,
  input  logic [1:0] p2_move,
  input  logic       p2_valid,
  output logic       p2_ready,
  output logic [3:0] round,
  output logic [3:0] win,
  output logic [3:0] lose,
  output logic [1:0] result,
  output logic       result_valid,
  output logic       fin,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {IDLE, WAIT, JUDGE, SHOW, DONE} state_t;

  state_t     state;
  logic [1:0] p1_hold, p2_hold;
  logic       p1_held, p2_held;
  logic [7:0] show_cnt;
  logic       p1_cap, p2_cap;
  logic [1:0] outcome;
  logic [1:0] match_winner;
  logic [4:0] remaining, win_ext, lose_ext;
  logic       finish;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b01 && b == 2'b11) ||
           (a == 2'b11 && b == 2'b10) ||
           (a == 2'b10 && b == 2'b01);
  endfunction

  // Ready depends only on registered state, so no input-to-output path exists.
  assign p1_ready = (state == WAIT) && !p1_held;
  assign p2_ready = (state == WAIT) && !p2_held;
  assign p1_cap   = p1_valid && p1_ready && (p1_move != 2'b00);
  assign p2_cap   = p2_valid && p2_ready && (p2_move != 2'b00);

  always_comb begin
    outcome = 2'b11;
    if (p1_hold == p2_hold)
      outcome = 2'b01;
    else if (beats(p1_hold, p2_hold))
      outcome = 2'b10;
  end

  always_comb begin
    match_winner = 2'b01;
    if (win > lose)
      match_winner = 2'b10;
    else if (lose > win)
      match_winner = 2'b11;
  end

  // 5-bit arithmetic keeps count + remaining rounds from overflowing.
  always_comb begin
    remaining = 5'(ROUNDS) - {1'b0, round};
    win_ext   = {1'b0, win};
    lose_ext  = {1'b0, lose};
    finish    = (round == 4'(ROUNDS)) ||
                ((EARLY_FIN != 0) &&
                 ((win_ext > lose_ext + remaining) || (lose_ext > win_ext + remaining)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      p1_hold      <= '0;
      p2_hold      <= '0;
      p1_held      <= 1'b0;
      p2_held      <= 1'b0;
      show_cnt     <= '0;
      round        <= '0;
      win          <= '0;
      lose         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      fin          <= 1'b0;
      winner       <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start)
            state <= WAIT;
        end
        WAIT: begin
          if (p1_cap) begin
            p1_hold <= p1_move;
            p1_held <= 1'b1;
          end
          if (p2_cap) begin
            p2_hold <= p2_move;
            p2_held <= 1'b1;
          end
          if ((p1_held || p1_cap) && (p2_held || p2_cap))
            state <= JUDGE;
        end
        JUDGE: begin
          round <= round + 4'd1;
          if (outcome == 2'b10)
            win <= win + 4'd1;
          else if (outcome == 2'b11)
            lose <= lose + 4'd1;
          result       <= outcome;
          result_valid <= 1'b1;
          p1_hold      <= '0;
          p2_hold      <= '0;
          p1_held      <= 1'b0;
          p2_held      <= 1'b0;
          show_cnt     <= 8'(SHOW_CYCLES - 1);
          state        <= SHOW;
        end
        SHOW: begin
          if (show_cnt == '0) begin
            if (finish) begin
              fin    <= 1'b1;
              winner <= match_winner;
              state  <= DONE;
            end else begin
              state <= WAIT;
            end
          end else begin
            show_cnt <= show_cnt - 8'd1;
          end
        end
        DONE: begin
          if (start) begin
            round  <= '0;
            win    <= '0;
            lose   <= '0;
            result <= '0;
            winner <= '0;
            fin    <= 1'b0;
            state  <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
